// File: rtl/br_predictor.sv
// Branch history table: 2-bit saturating counters trained from the commit bus,
// answering fetch-side direction queries one cycle later.
module br_predictor #(
  parameter int         INDEX_WIDTH  = 8,
  parameter logic [1:0] COUNTER_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        valid_from_rob_bus,
  input  logic [31:0] pc_from_rob_bus,
  input  logic        is_taken_from_rob_bus,
  input  logic        reset_from_rob_bus,
  input  logic        query_valid_from_inst_fetcher,
  input  logic [31:0] pc_from_inst_fetcher,
  output logic        pred_valid_to_inst_fetcher,
  output logic        pred_taken_to_inst_fetcher,
  output logic [31:0] pred_pc_to_inst_fetcher,
  output logic [31:0] commit_count,
  output logic [31:0] miss_count
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;

  logic [1:0] table_r [ENTRIES];

  logic                   commit_s;
  logic                   query_s;
  logic                   flush_s;
  logic [INDEX_WIDTH-1:0] upd_idx_s;
  logic [INDEX_WIDTH-1:0] qry_idx_s;
  logic [1:0]             upd_old_s;
  logic [1:0]             upd_new_s;
  logic [1:0]             qry_ctr_s;
  logic                   mispredict_s;
  logic                   unused_pc_bits_s;

  function automatic logic [1:0] next_counter(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
    end else begin
      res = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    end
    return res;
  endfunction

  assign unused_pc_bits_s = ^{pc_from_rob_bus[31:INDEX_WIDTH+2], pc_from_rob_bus[1:0]};

  // Decode commit/query, compute the counter update and the bypassed query value.
  always_comb begin
    commit_s     = valid_from_rob_bus & rdy;
    query_s      = query_valid_from_inst_fetcher & rdy;
    flush_s      = reset_from_rob_bus & rdy;
    upd_idx_s    = pc_from_rob_bus[INDEX_WIDTH+1:2];
    qry_idx_s    = pc_from_inst_fetcher[INDEX_WIDTH+1:2];
    upd_old_s    = table_r[upd_idx_s];
    upd_new_s    = next_counter(upd_old_s, is_taken_from_rob_bus);
    mispredict_s = upd_old_s[1] ^ is_taken_from_rob_bus;
    if (commit_s && (upd_idx_s == qry_idx_s)) begin
      qry_ctr_s = upd_new_s;
    end else begin
      qry_ctr_s = table_r[qry_idx_s];
    end
  end

  // Counter table: reset to the init value, written on each accepted commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_r[i] <= COUNTER_INIT;
      end
    end else if (commit_s) begin
      table_r[upd_idx_s] <= upd_new_s;
    end else begin
      table_r[upd_idx_s] <= table_r[upd_idx_s];
    end
  end

  // Commit and misprediction statistics, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_count <= 32'd0;
      miss_count   <= 32'd0;
    end else if (commit_s) begin
      commit_count <= commit_count + 32'd1;
      miss_count   <= miss_count + {31'd0, mispredict_s};
    end else begin
      commit_count <= commit_count;
      miss_count   <= miss_count;
    end
  end

  // Registered prediction response; a flush cancels the response of its cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_valid_to_inst_fetcher <= 1'b0;
      pred_taken_to_inst_fetcher <= 1'b0;
      pred_pc_to_inst_fetcher    <= 32'd0;
    end else if (rdy) begin
      pred_valid_to_inst_fetcher <= query_s & ~flush_s;
      if (query_s && !flush_s) begin
        pred_taken_to_inst_fetcher <= qry_ctr_s[1];
        pred_pc_to_inst_fetcher    <= pc_from_inst_fetcher;
      end else begin
        pred_taken_to_inst_fetcher <= pred_taken_to_inst_fetcher;
        pred_pc_to_inst_fetcher    <= pred_pc_to_inst_fetcher;
      end
    end else begin
      pred_valid_to_inst_fetcher <= pred_valid_to_inst_fetcher;
      pred_taken_to_inst_fetcher <= pred_taken_to_inst_fetcher;
      pred_pc_to_inst_fetcher    <= pred_pc_to_inst_fetcher;
    end
  end

endmodule

// File: tb/tb_br_predictor.sv
// Scoreboard bench for br_predictor: directed commits/queries with hand-computed
// expectations; a negedge monitor pops and compares every fresh response.
module tb_br_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        valid;
  logic [31:0] cpc;
  logic        ctaken;
  logic        flush;
  logic        qv;
  logic [31:0] qpc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic [31:0] commit_count;
  logic [31:0] miss_count;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q [$];
  logic        rdy_q = 1'b0;

  br_predictor #(.INDEX_WIDTH(8), .COUNTER_INIT(2'b01)) dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .rdy                           (rdy),
    .valid_from_rob_bus            (valid),
    .pc_from_rob_bus               (cpc),
    .is_taken_from_rob_bus         (ctaken),
    .reset_from_rob_bus            (flush),
    .query_valid_from_inst_fetcher (qv),
    .pc_from_inst_fetcher          (qpc),
    .pred_valid_to_inst_fetcher    (pred_valid),
    .pred_taken_to_inst_fetcher    (pred_taken),
    .pred_pc_to_inst_fetcher       (pred_pc),
    .commit_count                  (commit_count),
    .miss_count                    (miss_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rdy_q <= rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a response is fresh when the edge that produced it had rdy high.
  always @(negedge clk) begin
    if (rst_n && rdy_q && pred_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got pc 0x%08h taken %0d expected none", pred_pc, pred_taken);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_taken", {31'd0, pred_taken}, {31'd0, e[32]});
        chk("resp_pc", pred_pc, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic t);
    valid = 1'b1; cpc = pc; ctaken = t;
    tick();
    valid = 1'b0;
  endtask

  task automatic query(input logic [31:0] pc, input logic exp_t);
    qv = 1'b1; qpc = pc;
    exp_q.push_back({exp_t, pc});
    tick();
    qv = 1'b0;
    tick();
  endtask

  task automatic counts(input string name, input logic [31:0] c, input logic [31:0] m);
    chk({name, "_commit"}, commit_count, c);
    chk({name, "_miss"}, miss_count, m);
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; valid = 1'b0; cpc = 32'd0; ctaken = 1'b0;
    flush = 1'b0; qv = 1'b0; qpc = 32'd0;
    tick(); tick();
    chk("rst_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pc", pred_pc, 32'd0);
    counts("rst", 32'd0, 32'd0);
    rst_n = 1'b1;
    tick();

    query(32'h100, 1'b0);
    chk("idle_valid", {31'd0, pred_valid}, 32'd0);
    chk("idle_pc_hold", pred_pc, 32'h100);
    counts("after_q", 32'd0, 32'd0);

    // 1 -> 2 (miss) -> 3
    commit(32'h100, 1'b1);
    commit(32'h100, 1'b1);
    query(32'h100, 1'b1);
    counts("train", 32'd2, 32'd1);

    // saturate at 3, then one not-taken (miss) -> 2
    commit(32'h100, 1'b1);
    commit(32'h100, 1'b1);
    commit(32'h100, 1'b1);
    commit(32'h100, 1'b0);
    query(32'h100, 1'b1);
    counts("sat", 32'd6, 32'd2);

    // 0x000 and 0x400 alias to index 0; 0x004 is index 1
    commit(32'h000, 1'b1);
    commit(32'h000, 1'b1);
    query(32'h400, 1'b1);
    query(32'h004, 1'b0);
    counts("alias", 32'd8, 32'd3);

    // bypass: commit and query 0x200 together, counter 1 -> 2
    valid = 1'b1; cpc = 32'h200; ctaken = 1'b1;
    qv = 1'b1; qpc = 32'h200;
    exp_q.push_back({1'b1, 32'h200});
    tick();
    valid = 1'b0; qv = 1'b0;
    tick();
    counts("bypass", 32'd9, 32'd4);

    // flush with commit and query in the same cycle: no response
    valid = 1'b1; cpc = 32'h300; ctaken = 1'b1;
    qv = 1'b1; qpc = 32'h300; flush = 1'b1;
    tick();
    valid = 1'b0; qv = 1'b0; flush = 1'b0;
    chk("flush_valid", {31'd0, pred_valid}, 32'd0);
    counts("flush", 32'd10, 32'd5);
    tick();
    query(32'h300, 1'b1);

    // stall: a pending response holds while rdy is low
    qv = 1'b1; qpc = 32'h004;
    exp_q.push_back({1'b0, 32'h004});
    tick();
    rdy = 1'b0;
    valid = 1'b1; cpc = 32'h004; ctaken = 1'b1; qpc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'd0, pred_valid}, 32'd1);
      chk("stall_taken", {31'd0, pred_taken}, 32'd0);
      chk("stall_pc", pred_pc, 32'h004);
      counts("stall", 32'd10, 32'd5);
    end
    valid = 1'b0; qv = 1'b0; rdy = 1'b1;
    tick();
    chk("unstall_valid", {31'd0, pred_valid}, 32'd0);
    query(32'h004, 1'b0);

    // wrap: counter at 3 for index 0, so no miss
    @(negedge clk);
    force dut.commit_count = 32'hFFFF_FFFF;
    #1;
    release dut.commit_count;
    @(posedge clk); #1;
    chk("preload", commit_count, 32'hFFFF_FFFF);
    commit(32'h000, 1'b1);
    counts("wrap", 32'd0, 32'd5);

    tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/br_predictor.md
# br_predictor

Branch history table at the consumer end of the commit bus. It learns from the committed-branch stream (`valid`/`pc`/`is_taken`) that the reorder buffer drives through `rob_bus`, and answers per-PC taken/not-taken queries from `inst_fetcher` one cycle later. It keeps one 2-bit saturating counter per table entry, plus commit and misprediction statistics.

## Interface
Parameters:
- `INDEX_WIDTH`, 8: log2 of table entries; index = `pc[INDEX_WIDTH+1:2]`.
- `COUNTER_INIT`, 2'b01: reset value of every counter (weakly not-taken).

Ports:
- `clk`  in  1  the single clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rdy`  in  1  global ready; while low, all state and outputs hold.
- `valid_from_rob_bus`  in  1  committed branch this cycle.
- `pc_from_rob_bus`  in  32  PC of the committed branch.
- `is_taken_from_rob_bus`  in  1  actual outcome of the committed branch.
- `reset_from_rob_bus`  in  1  pipeline flush.
- `query_valid_from_inst_fetcher`  in  1  prediction request.
- `pc_from_inst_fetcher`  in  32  PC to predict.
- `pred_valid_to_inst_fetcher`  out  1  response valid, one-cycle pulse per query.
- `pred_taken_to_inst_fetcher`  out  1  predicted direction.
- `pred_pc_to_inst_fetcher`  out  32  echo of the queried PC.
- `commit_count`  out  32  number of committed branches.
- `miss_count`  out  32  number of committed branches that were mispredicted.

## Operation
- **Table:** 2^INDEX_WIDTH counters, each 2 bits.
- **Counter update rule:**
  - taken: counter = min(counter+1, 3).
  - not taken: counter = max(counter−1, 0).
- **Prediction:** taken = counter[1].
- **Commit update** (`valid_from_rob_bus` & `rdy`), applied at the clock edge:
  - write the updated counter to the entry at idx(`pc_from_rob_bus`);
  - `commit_count` += 1;
  - if the counter's pre-update bit 1 differs from `is_taken_from_rob_bus`, `miss_count` += 1.
  - Both counts are 32-bit and wrap modulo 2^32 (0xFFFFFFFF+1 → 0).
- **Query** (`query_valid_from_inst_fetcher` & `rdy`): at the next edge, register the prediction for idx(`pc_from_inst_fetcher`) and the echoed PC, and raise `pred_valid`.
- **Same-cycle update and query to the same index:** the query sees the post-update counter (bypass).
- **Same-cycle update and query to different indexes:** independent.
- **Aliasing:** PCs sharing bits [INDEX_WIDTH+1:2] share one counter. There are no tags.
- **Flush** (`reset_from_rob_bus` & `rdy`):
  - `pred_valid` is 0 on the next cycle, even if a query arrives in the same cycle.
  - A commit update in the same cycle is still applied, including counter and statistics changes.
  - Table contents are not cleared.
- **`rdy` low:** no table write, no count change; outputs hold their current values, including a `pred_valid` of 1.
- **No-query cycle:** `pred_valid` drops to 0 on the next edge; `pred_taken` and `pred_pc` hold their last values.
- **Reset** (`rst_n` low at an edge, overriding all other inputs):
  - every counter = `COUNTER_INIT`;
  - `pred_valid` = 0, `pred_taken` = 0, `pred_pc` = 0;
  - `commit_count` = 0, `miss_count` = 0.
  - Reset mid-operation discards an in-flight response.

## Timing
- **Query latency:** 1 cycle. A query at edge N yields `pred_valid` high during cycle N+1.
- **Throughput:** one query per cycle; back-to-back queries give a continuous `pred_valid`.
- **Commit to visibility:** an update at edge N affects a query sampled at edge N (bypass) and all later queries.
- **Statistics:** both counts are visible the cycle after the commit edge.
- **Flush:** the response is cancelled at the edge where the flush is sampled.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.

## Test plan
- **Reset:** hold `rst_n`=0 two cycles, then query PC 0x100 → `pred_valid`=1, `pred_taken`=0, `pred_pc`=0x100 next cycle; both counts 0.
- **Training and saturation:**
  - Commit PC 0x100 taken twice, then query → `pred_taken`=1; `commit_count`=2, `miss_count`=1.
  - Commit taken 3 more times, then not-taken once, then query → `pred_taken`=1 (3→2).
- **Aliasing (INDEX_WIDTH=8):** commit 0x000 taken ×2, then query 0x400 → `pred_taken`=1; query 0x004 → `pred_taken`=0.
- **Bypass:** with counter at 1 for 0x200, commit 0x200 taken and query 0x200 in the same cycle → next cycle `pred_taken`=1.
- **Flush:** query 0x300 with `reset_from_rob_bus`=1 and a commit of 0x300 taken in the same cycle → `pred_valid`=0 next cycle; a later query → `pred_taken`=1; `commit_count` incremented.
- **Stall and wrap:**
  - `rdy`=0 for 3 cycles with a commit and a query asserted → no count change, outputs unchanged.
  - Preload `commit_count` to 0xFFFFFFFF via 2^32−1 commits (force in bench), then one more commit → 0.
